conv1d_cpa_accum: RTL
=====================

Name: conv1d_cpa_accum

Overview:
Final stage of the conv1d multiply-accumulate path. It takes the redundant (sum, cout) pair from the 8-to-2 partial-product compressor and resolves it into a 32-bit two's-complement product with a carry-propagate adder. It then accumulates KERNEL_LEN consecutive products into one convolution output, rounds and saturates the result, and presents it on a valid/ready output port.

Parameters:
WIDTH_DATA, 16, operand width; the product and the sum/cout inputs are 2*WIDTH_DATA = 32 bits
KERNEL_LEN, 3, number of taps (products) accumulated per output; must be ≥ 1
WIDTH_ACC, 40, accumulator width; must be ≥ 2*WIDTH_DATA + clog2(KERNEL_LEN)
FRAC_BITS, 8, right shift applied to the accumulator before saturation; must be ≥ 1
WIDTH_OUT, 16, signed output width

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
sync_clr  input  1  synchronous flush of the in-flight accumulation
in_valid  input  1  in_sum and in_cout are valid
in_ready  output  1  block accepts the input this cycle
in_sum  input  2*WIDTH_DATA  compressor sum vector
in_cout  input  2*WIDTH_DATA  compressor carry vector, unshifted (weight 2^(i+1) at bit i)
out_valid  output  1  out_data and out_sat are valid
out_ready  input  1  downstream accepts the output this cycle
out_data  output  WIDTH_OUT  rounded, saturated convolution result, signed
out_sat  output  1  out_data was clipped

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid, tap counter, accumulator, out_valid, out_data and out_sat all clear to 0. in_ready is combinational and reads 1 while the state is cleared.
- Input handshake: a tap is accepted on an edge where in_valid && in_ready.
- Stage 1 (CPA register): on accept, prod <= in_sum + {in_cout[2W-2:0],1'b0}, computed mod 2^(2W) and treated as signed. s1_valid <= 1.
- s1 advance: s1 advances when s1_valid && !stall2. Otherwise s1_valid <= 0 unless a new tap is accepted on the same edge.
- in_ready = !s1_valid || s1_advance. Full-throughput streaming is supported with no bubbles.
- Stage 2 tap FSM, driven by tap counter t in 0..KERNEL_LEN-1:
  - FIRST (t==0): acc <= sext(prod).
  - MID: acc <= acc + sext(prod).
  - LAST (t==KERNEL_LEN-1): the final sum is formed, the result is produced, and t wraps to 0.
  - With KERNEL_LEN==1, every tap is both FIRST and LAST.
- stall2 = (t==KERNEL_LEN-1) && out_valid && !out_ready. Only the last tap stalls; FIRST and MID taps never stall.
- Result formation:
  - r = (acc_final + 2^(FRAC_BITS-1)) >>> FRAC_BITS, an arithmetic shift (round half toward +inf).
  - If r > 2^(WIDTH_OUT-1)-1: out_data = max, out_sat = 1.
  - If r < -2^(WIDTH_OUT-1): out_data = min, out_sat = 1.
  - Otherwise out_data = r[WIDTH_OUT-1:0], out_sat = 0.
  - The accumulator never overflows internally.
- Output register: single entry. When loaded, out_valid <= 1. out_data and out_sat are held stable while out_valid && !out_ready. out_valid clears after an edge with out_ready, unless a new result loads on that same edge (back-to-back).
- Latency: the last tap accepted at edge N gives out_valid high after edge N+2.
- sync_clr (priority over all other activity on the same edge):
  - s1_valid <= 0, t <= 0, acc <= 0.
  - A tap presented on that edge is dropped; in_ready is still reported, so the tap is consumed and discarded.
  - The output register and out_valid are unaffected.
- Reset mid-accumulation discards partial taps. The next accepted tap is FIRST.
- Outputs never change while rst_n is low.

Test Plan:
- Basic (defaults): three taps (sum,cout) = (0x100,0x080), (0x300,0x000), (0x000,0x080). Products are 0x200, 0x300, 0x100; acc = 0x600 -> out_data = 0x0006, out_sat = 0. out_valid rises 2 edges after the 3rd accept.
- Negative rounding: three taps sum = 0xFFFFFF00, cout = 0. acc = -768, (-768+128)>>>8 = -3 -> out_data = 0xFFFD, out_sat = 0.
- Saturation:
  - Three taps sum = 0x7FFFFFFF, cout = 0 -> out_data = 0x7FFF, out_sat = 1.
  - Three taps sum = 0x80000000, cout = 0 -> out_data = 0x8000, out_sat = 1.
- Backpressure: hold out_ready = 0 and stream 6 valid taps continuously. First result is held; the 6th tap stalls, so in_ready drops while both s1 and the last-tap stage are full. Raise out_ready: both results emerge in order, with no loss or duplication.
- Mid-accumulation reset: accept 2 taps of 0x7FFF0000, pulse rst_n low for 1 cycle, then send the Basic sequence -> out_data = 0x0006.
- sync_clr on the 2nd tap's accept edge: send tap 1, then tap 2 with sync_clr, then the Basic sequence -> 0x0006 with no leftover. A pending output held under out_ready = 0 survives the clear unchanged.

Source files
------------

// File: rtl/conv1d_cpa_accum.sv
// Resolves compressor (sum, cout) pairs into products and accumulates KERNEL_LEN taps into one rounded, saturated output.
// Latency 2 edges from last-tap accept to out_valid; only the last tap stalls, and only when a held result blocks the output.
module conv1d_cpa_accum #(
   parameter int WIDTH_DATA = 16,
   parameter int KERNEL_LEN = 3,
   parameter int WIDTH_ACC  = 40,
   parameter int FRAC_BITS  = 8,
   parameter int WIDTH_OUT  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    sync_clr,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [2*WIDTH_DATA-1:0] in_sum,
   input  logic [2*WIDTH_DATA-1:0] in_cout,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH_OUT-1:0]    out_data,
   output logic                    out_sat
);

   localparam int PW = 2 * WIDTH_DATA;
   localparam int TW = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;
   localparam int RW = WIDTH_ACC + 1;
   localparam logic [TW-1:0]        T_LAST   = TW'(KERNEL_LEN - 1);
   localparam logic signed [RW-1:0] RND_HALF = {{(RW-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);
   localparam logic signed [RW-1:0] OUT_MAX  = RW'((64'd1 << (WIDTH_OUT - 1)) - 64'd1);
   localparam logic signed [RW-1:0] OUT_MIN  = ~OUT_MAX;

   logic                  s1_vld_q, s1_vld_d;
   logic [PW-1:0]         prod_q, prod_d;
   logic [TW-1:0]         tap_q, tap_d;
   logic [WIDTH_ACC-1:0]  acc_q, acc_d;
   logic                  pend_q, pend_d;
   logic                  out_vld_q, out_vld_d;
   logic [WIDTH_OUT-1:0]  out_dat_q, out_dat_d;
   logic                  out_sat_q, out_sat_d;

   logic                  is_first, is_last, stall2, s1_adv, accept;
   logic [PW-1:0]         cout_sh, cpa_sum;
   logic [WIDTH_ACC-1:0]  prod_ext, acc_base;
   logic signed [RW-1:0]  rnd, r;

   always_comb begin
      is_first = (tap_q == '0);
      is_last  = (tap_q == T_LAST);
      // pend_q only matters for KERNEL_LEN==1, where back-to-back last taps
      // would otherwise race a result still on its way to the output register
      stall2   = is_last && ((out_vld_q && !out_ready) || pend_q);
      s1_adv   = s1_vld_q && !stall2;
      in_ready = !s1_vld_q || s1_adv;
      accept   = in_valid && in_ready;

      cout_sh  = in_cout << 1;
      cpa_sum  = in_sum + cout_sh;
      prod_ext = {{(WIDTH_ACC-PW){prod_q[PW-1]}}, prod_q};
      acc_base = is_first ? '0 : acc_q;

      // acc_q holds the completed sum while pend_q is set
      rnd = $signed({acc_q[WIDTH_ACC-1], acc_q}) + RND_HALF;
      r   = rnd >>> FRAC_BITS;
   end

   always_comb begin
      s1_vld_d  = s1_vld_q;
      prod_d    = prod_q;
      tap_d     = tap_q;
      acc_d     = acc_q;
      pend_d    = 1'b0;
      out_vld_d = out_vld_q;
      out_dat_d = out_dat_q;
      out_sat_d = out_sat_q;

      if (sync_clr) begin
         s1_vld_d = 1'b0;
         tap_d    = '0;
         acc_d    = '0;
      end else begin
         if (accept) begin
            prod_d   = cpa_sum;
            s1_vld_d = 1'b1;
         end else if (s1_adv) begin
            s1_vld_d = 1'b0;
         end

         if (s1_adv) begin
            acc_d = acc_base + prod_ext;
            if (is_last) begin
               tap_d  = '0;
               pend_d = 1'b1;
            end else begin
               tap_d = tap_q + TW'(1);
            end
         end
      end

      // A finished sum always loads: stall2 guaranteed the slot is free
      if (pend_q) begin
         out_vld_d = 1'b1;
         if (r > OUT_MAX) begin
            out_dat_d = OUT_MAX[WIDTH_OUT-1:0];
            out_sat_d = 1'b1;
         end else if (r < OUT_MIN) begin
            out_dat_d = OUT_MIN[WIDTH_OUT-1:0];
            out_sat_d = 1'b1;
         end else begin
            out_dat_d = r[WIDTH_OUT-1:0];
            out_sat_d = 1'b0;
         end
      end else if (out_ready) begin
         out_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q  <= 1'b0;
         prod_q    <= '0;
         tap_q     <= '0;
         acc_q     <= '0;
         pend_q    <= 1'b0;
         out_vld_q <= 1'b0;
         out_dat_q <= '0;
         out_sat_q <= 1'b0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         prod_q    <= prod_d;
         tap_q     <= tap_d;
         acc_q     <= acc_d;
         pend_q    <= pend_d;
         out_vld_q <= out_vld_d;
         out_dat_q <= out_dat_d;
         out_sat_q <= out_sat_d;
      end
   end

   assign out_valid = out_vld_q;
   assign out_data  = out_dat_q;
   assign out_sat   = out_sat_q;

endmodule
